// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between decode/execute and the PC sequencer.
// Carries exc_req/epc only when EXC_VECTOR_EN is defined.
interface pc_sequencer_if #(parameter int CNT_W = 16);
  logic              stall;
  logic              br_req;
  logic              br_taken;
  logic [15:0]       br_offset;
  logic              j_req;
  logic [25:0]       j_index;
  logic              jr_req;
  logic [31:0]       jr_target;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              flush;
  logic              jr_misalign;
  logic [CNT_W-1:0]  redirect_cnt;
`ifdef EXC_VECTOR_EN
  logic              exc_req;
  logic [31:0]       epc;
`endif

  modport master (
    output stall, br_req, br_taken, br_offset, j_req, j_index, jr_req, jr_target,
`ifdef EXC_VECTOR_EN
    output exc_req,
    input  epc,
`endif
    input  pc, pc_plus4, flush, jr_misalign, redirect_cnt
  );

  modport slave (
    input  stall, br_req, br_taken, br_offset, j_req, j_index, jr_req, jr_target,
`ifdef EXC_VECTOR_EN
    input  exc_req,
    output epc,
`endif
    output pc, pc_plus4, flush, jr_misalign, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program counter sequencer: next-PC select, stall, one-cycle wrong-path flush.
// Optional exception vectoring is enabled with the EXC_VECTOR_EN macro.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       pc_r, pc_nxt, pc_plus4;
  logic              flush_r, mis_r, mis_nxt, redirect;
  logic [CNT_W-1:0]  cnt_r;
  logic [31:0]       br_target, j_target, jr_aligned;

  assign pc_plus4   = pc_r + 32'd4;
  assign br_target  = pc_plus4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
  assign j_target   = {pc_plus4[31:28], bus.j_index, 2'b00};
  assign jr_aligned = {bus.jr_target[31:2], 2'b00};

`ifdef EXC_VECTOR_EN
  logic [31:0] epc_r, epc_nxt;
`else
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    mis_nxt   = 1'b0;
    redirect  = 1'b0;
`ifdef EXC_VECTOR_EN
    epc_nxt   = epc_r;
`endif
    case (state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.jr_req) begin
            pc_nxt   = jr_aligned;
            mis_nxt  = |bus.jr_target[1:0];
            redirect = 1'b1;
          end else if (bus.j_req) begin
            pc_nxt   = j_target;
            redirect = 1'b1;
          end else if (bus.br_req && bus.br_taken) begin
            pc_nxt   = br_target;
            redirect = 1'b1;
          end else begin
            pc_nxt   = pc_plus4;
          end
        end
      end
      REDIRECT: begin
        // Requests here belong to the instruction being flushed.
        state_nxt = RUN;
        if (!bus.stall) pc_nxt = pc_plus4;
      end
      default: state_nxt = RUN;
    endcase
`ifdef EXC_VECTOR_EN
    if (bus.exc_req) begin
      pc_nxt   = EXC_VECTOR;
      epc_nxt  = pc_r;
      mis_nxt  = 1'b0;
      redirect = 1'b1;
    end
`endif
    if (redirect) state_nxt = REDIRECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc_r    <= RESET_PC;
      flush_r <= 1'b0;
      mis_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_nxt;
      pc_r    <= pc_nxt;
      flush_r <= redirect;
      mis_r   <= mis_nxt;
      if (redirect && cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + 1'b1;
    end
  end

`ifdef EXC_VECTOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) epc_r <= 32'h0;
    else     epc_r <= epc_nxt;
  end
  assign bus.epc = epc_r;
`endif

  assign bus.pc           = pc_r;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.flush        = flush_r;
  assign bus.jr_misalign  = mis_r;
  assign bus.redirect_cnt = cnt_r;

endmodule
